// File: rtl/term_char_writer.sv
// Terminal character writer: turns a UART byte stream into text-RAM writes,
// tracking a cursor and scrolling the screen through a circular row offset.
module term_char_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_Wr_En,
    output logic [11:0] o_Wr_Addr,
    output logic [7:0]  o_Wr_Data,
    input  logic        i_Wr_Ready,
    output logic [4:0]  o_Top_Row,
    output logic [6:0]  o_Cursor_Col,
    output logic [4:0]  o_Cursor_Row,
    output logic        o_Busy,
    output logic        o_Overflow
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t      state, next_state;
    logic        hold_full;
    logic [7:0]  hold_byte;
    logic        overflow;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  top_row;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [6:0]  clr_col;

    logic        consume, capture, accept;
    logic        start_write, do_lf, do_cr, do_bs, col_inc;
    logic        at_bottom, printable;
    logic [5:0]  phys_sum;
    logic [4:0]  phys_row, top_inc;
    logic [11:0] cursor_addr, top_base;

    // The holding register can refill in the same cycle IDLE drains it.
    assign consume   = (state == IDLE) && hold_full;
    assign capture   = i_RX_DV && (!hold_full || consume);
    assign accept    = wr_en && i_Wr_Ready;
    assign at_bottom = (row == LAST_ROW);
    assign printable = (hold_byte >= 8'h20) && (hold_byte <= 8'h7E);

    // Both operands are below ROWS, so one conditional subtract is a full mod.
    assign phys_sum    = {1'b0, top_row} + {1'b0, row};
    assign phys_row    = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];
    assign cursor_addr = 12'(phys_row) * 12'(COLS) + 12'(col);
    assign top_inc     = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
    // After a scroll the new bottom row is the physical row that was on top.
    assign top_base    = 12'(top_row) * 12'(COLS);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        start_write = 1'b0;
        do_lf       = 1'b0;
        do_cr       = 1'b0;
        do_bs       = 1'b0;
        col_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    if (printable) begin
                        start_write = 1'b1;
                        next_state  = WRITE;
                    end else if (hold_byte == 8'h0A) begin
                        do_lf = 1'b1;
                        if (at_bottom) next_state = CLEAR;
                    end else if (hold_byte == 8'h0D) begin
                        do_cr = 1'b1;
                    end else if (hold_byte == 8'h08) begin
                        do_bs = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    if (col == LAST_COL) begin
                        do_lf      = 1'b1;
                        do_cr      = 1'b1;
                        next_state = at_bottom ? CLEAR : IDLE;
                    end else begin
                        col_inc    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (accept && clr_col == LAST_COL) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hold_full <= 1'b0;
            hold_byte <= 8'h00;
            overflow  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 12'd0;
            wr_data   <= 8'h00;
            top_row   <= 5'd0;
            col       <= 7'd0;
            row       <= 5'd0;
            clr_col   <= 7'd0;
        end else begin
            if (capture) hold_byte <= i_RX_Byte;
            hold_full <= capture || (hold_full && !consume);
            overflow  <= i_RX_DV && hold_full && !consume;

            if (start_write) begin
                wr_addr <= cursor_addr;
                wr_data <= hold_byte;
            end

            // Request rises the cycle after entering WRITE/CLEAR, so address
            // and data are already registered when the RAM first sees it.
            if (state == WRITE || state == CLEAR) begin
                if (!wr_en) begin
                    wr_en <= 1'b1;
                end else if (accept) begin
                    if (state == CLEAR && clr_col != LAST_COL) begin
                        clr_col <= clr_col + 7'd1;
                        wr_addr <= wr_addr + 12'd1;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
            end

            if (col_inc)                   col <= col + 7'd1;
            if (do_cr)                     col <= 7'd0;
            if (do_bs && col != 7'd0)      col <= col - 7'd1;

            if (do_lf) begin
                if (!at_bottom) begin
                    row <= row + 5'd1;
                end else begin
                    top_row <= top_inc;
                    clr_col <= 7'd0;
                    wr_addr <= top_base;
                    wr_data <= 8'h20;
                end
            end
        end
    end

    assign o_Wr_En      = wr_en;
    assign o_Wr_Addr    = wr_addr;
    assign o_Wr_Data    = wr_data;
    assign o_Top_Row    = top_row;
    assign o_Cursor_Col = col;
    assign o_Cursor_Row = row;
    assign o_Busy       = (state != IDLE) || hold_full;
    assign o_Overflow   = overflow;

endmodule

// File: tb/tb_term_char_writer.sv
// Directed bench for term_char_writer: cursor motion, writes, scroll-clears,
// back-pressure, overflow and asynchronous reset.
module tb_term_char_writer;

    logic        i_Clock = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_RX_DV = 1'b0;
    logic [7:0]  i_RX_Byte = 8'h00;
    logic        i_Wr_Ready = 1'b1;
    logic        o_Wr_En;
    logic [11:0] o_Wr_Addr;
    logic [7:0]  o_Wr_Data;
    logic [4:0]  o_Top_Row;
    logic [6:0]  o_Cursor_Col;
    logic [4:0]  o_Cursor_Row;
    logic        o_Busy;
    logic        o_Overflow;

    int n_cmp = 0;
    int n_err = 0;
    int ovf_cnt = 0;
    logic [11:0] wa[$];
    logic [7:0]  wd[$];

    term_char_writer #(.COLS(80), .ROWS(30)) dut (
        .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
        .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
        .i_Wr_Ready(i_Wr_Ready), .o_Top_Row(o_Top_Row), .o_Cursor_Col(o_Cursor_Col),
        .o_Cursor_Row(o_Cursor_Row), .o_Busy(o_Busy), .o_Overflow(o_Overflow)
    );

    always #5 i_Clock = ~i_Clock;

    // Log every accepted write and every overflow pulse.
    always @(posedge i_Clock) begin
        if (o_Wr_En && i_Wr_Ready) begin
            wa.push_back(o_Wr_Addr);
            wd.push_back(o_Wr_Data);
        end
        if (o_Overflow) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_Rst_n = 1'b0;
        i_RX_DV = 1'b0;
        repeat (2) @(negedge i_Clock);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge i_Clock);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(negedge i_Clock);
        i_RX_DV   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_Busy && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        if (o_Busy) chk("idle_timeout", 32'(o_Busy), 32'd0);
    endtask

    task automatic send_wait(input logic [7:0] b);
        send(b);
        wait_idle(400);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        int bad;
        // Reset state (held in reset from time 0)
        #12;
        chk("rst_wr_en", 32'(o_Wr_En), 0);
        chk("rst_addr", 32'(o_Wr_Addr), 0);
        chk("rst_data", 32'(o_Wr_Data), 0);
        chk("rst_top", 32'(o_Top_Row), 0);
        chk("rst_col", 32'(o_Cursor_Col), 0);
        chk("rst_row", 32'(o_Cursor_Row), 0);
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_ovf", 32'(o_Overflow), 0);
        do_reset();

        // Single 'A': request two edges after the sampling edge
        clear_log();
        @(negedge i_Clock);
        i_RX_DV = 1'b1; i_RX_Byte = 8'h41;
        @(negedge i_Clock);
        i_RX_DV = 1'b0;
        chk("a_en_e0", 32'(o_Wr_En), 0);
        @(negedge i_Clock);
        chk("a_en_e1", 32'(o_Wr_En), 0);
        @(negedge i_Clock);
        chk("a_en_e2", 32'(o_Wr_En), 1);
        chk("a_addr", 32'(o_Wr_Addr), 0);
        chk("a_data", 32'(o_Wr_Data), 32'h41);
        wait_idle(20);
        chk("a_nwr", wa.size(), 1);
        chk("a_col", 32'(o_Cursor_Col), 1);
        chk("a_row", 32'(o_Cursor_Row), 0);

        // Back-pressure: 'B' at col 1 held for 5 cycles
        clear_log();
        i_Wr_Ready = 1'b0;
        send(8'h42);
        repeat (2) @(negedge i_Clock);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_Wr_En !== 1'b1 || o_Wr_Addr !== 12'd1 || o_Wr_Data !== 8'h42 ||
                o_Cursor_Col !== 7'd1) bad++;
            @(negedge i_Clock);
        end
        chk("bp_stable_bad", bad, 0);
        chk("bp_no_wr", wa.size(), 0);
        i_Wr_Ready = 1'b1;
        wait_idle(20);
        chk("bp_nwr", wa.size(), 1);
        chk("bp_col", 32'(o_Cursor_Col), 2);

        // 80 'x' wrap to next row, then CR/BS and 'y'/BS
        do_reset();
        clear_log();
        for (int i = 0; i < 80; i++) send_wait(8'h78);
        chk("x_nwr", wa.size(), 80);
        chk("x_last_addr", (wa.size() > 0) ? 32'(wa[wa.size()-1]) : 32'hFFFF, 79);
        chk("x_col", 32'(o_Cursor_Col), 0);
        chk("x_row", 32'(o_Cursor_Row), 1);
        send_wait(8'h0D);
        send_wait(8'h08);
        chk("crbs_col", 32'(o_Cursor_Col), 0);
        chk("crbs_row", 32'(o_Cursor_Row), 1);
        clear_log();
        send_wait(8'h79);
        chk("y_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF, 80);
        chk("y_col", 32'(o_Cursor_Col), 1);
        send_wait(8'h08);
        chk("ybs_col", 32'(o_Cursor_Col), 0);
        send_wait(8'h01);
        chk("ctl_no_wr", wa.size(), 1);

        // Scroll at bottom: top 0 -> 1, clear physical row 0
        do_reset();
        for (int i = 0; i < 29; i++) send_wait(8'h0A);
        chk("lf_row29", 32'(o_Cursor_Row), 29);
        clear_log();
        send_wait(8'h0A);
        chk("sc1_top", 32'(o_Top_Row), 1);
        chk("sc1_nwr", wa.size(), 80);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== 12'(i) || wd[i] !== 8'h20) bad++;
        chk("sc1_bad", bad, 0);
        chk("sc1_row", 32'(o_Cursor_Row), 29);

        // Scroll to top 29, then wrap top 29 -> 0 clearing row 29
        for (int i = 0; i < 28; i++) send_wait(8'h0A);
        chk("sc_top29", 32'(o_Top_Row), 29);
        clear_log();
        send_wait(8'h71);
        chk("q_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF, 28 * 80);
        chk("q_data", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFF, 32'h71);
        clear_log();
        send_wait(8'h0A);
        chk("sc2_top", 32'(o_Top_Row), 0);
        chk("sc2_nwr", wa.size(), 80);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== 12'(29 * 80 + i) || wd[i] !== 8'h20) bad++;
        chk("sc2_bad", bad, 0);
        chk("sc2_col", 32'(o_Cursor_Col), 1);
        chk("sc2_row", 32'(o_Cursor_Row), 29);

        // Overflow: three strobes two cycles apart while RAM stalls
        do_reset();
        clear_log();
        ovf_cnt = 0;
        i_Wr_Ready = 1'b0;
        send(8'h43);
        @(negedge i_Clock);
        send(8'h44);
        @(negedge i_Clock);
        send(8'h45);
        repeat (4) @(negedge i_Clock);
        chk("ov_pulses", ovf_cnt, 1);
        i_Wr_Ready = 1'b1;
        wait_idle(40);
        chk("ov_nwr", wa.size(), 2);
        chk("ov_w0", (wa.size() > 1) ? {wa[0], wd[0]} : 32'hFFFFF, {12'd0, 8'h43});
        chk("ov_w1", (wa.size() > 1) ? {wa[1], wd[1]} : 32'hFFFFF, {12'd1, 8'h44});
        chk("ov_col", 32'(o_Cursor_Col), 2);

        // Reset in the middle of a clear
        do_reset();
        for (int i = 0; i < 29; i++) send_wait(8'h0A);
        clear_log();
        send(8'h0A);
        for (int i = 0; i < 200 && wa.size() < 40; i++) @(negedge i_Clock);
        chk("mid_reached", wa.size(), 40);
        i_Rst_n = 1'b0;
        #1;
        chk("mid_wr_en", 32'(o_Wr_En), 0);
        chk("mid_addr", 32'(o_Wr_Addr), 0);
        chk("mid_top", 32'(o_Top_Row), 0);
        chk("mid_row", 32'(o_Cursor_Row), 0);
        chk("mid_busy", 32'(o_Busy), 0);
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        repeat (20) @(negedge i_Clock);
        chk("mid_no_more_wr", wa.size(), 40);
        chk("mid_busy_after", 32'(o_Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/term_char_writer.md
TERM_CHAR_WRITER -- requirements
Module: term_char_writer

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 i_Clock  in  1  sole clock; all logic rising-edge.
REQ-004 i_Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_RX_DV  in  1  one-cycle strobe from UART receiver; byte valid.
REQ-006 i_RX_Byte  in  8  received byte, valid when i_RX_DV=1.
REQ-007 o_Wr_En  out  1  text-RAM write request.
REQ-008 o_Wr_Addr  out  12  text-RAM address = phys_row*COLS + col.
REQ-009 o_Wr_Data  out  8  character code to write.
REQ-010 i_Wr_Ready  in  1  RAM accepts write in any cycle where o_Wr_En=1 and i_Wr_Ready=1.
REQ-011 o_Top_Row  out  5  physical RAM row displayed at screen top; scroll offset for display scanner.
REQ-012 o_Cursor_Col  out  7  cursor column, 0..COLS-1.
REQ-013 o_Cursor_Row  out  5  cursor logical row, 0..ROWS-1.
REQ-014 o_Busy  out  1  high whenever FSM not in IDLE or holding register full.
REQ-015 o_Overflow  out  1  one-cycle pulse when an incoming byte is dropped.

Function
REQ-016 One-byte holding register; captures i_RX_Byte on every edge where i_RX_DV=1 and register empty or being consumed that same cycle.
REQ-017 i_RX_DV=1 while holding register full and not consumed: byte dropped, o_Overflow=1 next cycle, held byte unchanged.
REQ-018 FSM states: IDLE, WRITE, CLEAR; IDLE consumes holding register and decodes in one cycle.
REQ-019 Printable 0x20..0x7E: IDLE->WRITE; o_Wr_En rises two edges after the edge sampling i_RX_DV (register idle); addr = phys of cursor, data = byte.
REQ-020 WRITE holds o_Wr_En, o_Wr_Addr, o_Wr_Data stable until acceptance; on acceptance col+1, or if col=COLS-1 then col=0 and line feed (REQ-022); FSM returns to IDLE unless CLEAR entered.
REQ-021 CR 0x0D: col=0, stay IDLE; BS 0x08: col-1 if col>0 else no change, non-destructive; all other bytes ignored, no write.
REQ-022 LF 0x0A (or wrap): if row<ROWS-1 row+1; else row unchanged, o_Top_Row=(o_Top_Row+1) mod ROWS, enter CLEAR.
REQ-023 phys_row = (o_Top_Row + row) mod ROWS, computed without multiplier-wide overflow; 12-bit address, max ROWS*COLS-1.
REQ-024 CLEAR writes 0x20 to all COLS cells of the new bottom physical row, col index 0..COLS-1 ascending, one accepted write per handshake, then IDLE; cursor col unchanged (0 on wrap, preserved on bare LF).
REQ-025 o_Wr_En low in IDLE; never asserted for non-printable bytes except CLEAR fills.
REQ-026 Holding register keeps accepting one byte during WRITE/CLEAR; processed in arrival order.
REQ-027 o_Top_Row wraps ROWS-1 -> 0; cursor counters never exceed limits.

Reset
REQ-028 i_Rst_n=0 asynchronously forces: state IDLE, holding empty, o_Wr_En=0, o_Wr_Addr=0, o_Wr_Data=0, o_Top_Row=0, cursor (0,0), o_Busy=0, o_Overflow=0.
REQ-029 Reset mid-WRITE or mid-CLEAR abandons operation; no further write issued; screen RAM not cleared by this block.

Verification
REQ-030 Reset, send 'A' (0x41), i_Wr_Ready=1 -> one write addr 0 data 0x41, o_Wr_En high 2 edges after DV, cursor (1,0).
REQ-031 i_Wr_Ready=0 for 5 cycles during WRITE -> addr/data stable, cursor unchanged until ready, exactly one accepted write.
REQ-032 80 bytes 'x' from (0,0) -> last write addr 79, cursor (0,1); then CR, BS -> cursor (0,1); 'y' then BS -> col 0.
REQ-033 Cursor row 29, top 0, send LF -> o_Top_Row=1, 80 writes 0x20 addr 0..79, cursor row 29; repeat with top 29 -> top 0, clear addr 29*80..29*80+79.
REQ-034 Three DV strobes 2 cycles apart while i_Wr_Ready=0 -> second held, third dropped, o_Overflow one pulse; first two bytes written in order.
REQ-035 Assert i_Rst_n=0 during CLEAR at cell 40 -> o_Wr_En=0 immediately, all outputs at reset values, no writes after release until new byte.
